seg_mux_display_gen: RTL and testbench

Parametrised multiplexed 7-segment display driver for the lab timer and clock designs. It displays NUM_FIELDS two-digit decimal fields, such as minutes and seconds.
- Binary field values are captured on a load handshake and converted to BCD sequentially.
- The converted digits are committed atomically to a display buffer.
- The buffer is scanned onto the common-anode digits with a built-in refresh prescaler, per-field blink, per-digit decimal point and tens-digit zero blanking.
- It sits between the counter/FSM logic and the board's seg/dp/an pins, and runs entirely on the system clock.

---
 rtl/seg_mux_display_gen.sv | 215 +++++++++++++++++++++
 tb/tb_seg_mux_display_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/seg_mux_display_gen.sv
// Multiplexed common-anode 7-segment driver: captures binary two-digit fields,
// converts them to BCD by repeated subtraction, then scans the committed digits.
module seg_mux_display_gen #(
    parameter int NUM_FIELDS  = 2,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_DIV   = 250,
    localparam int NUM_DIGITS = 2 * NUM_FIELDS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [7*NUM_FIELDS-1:0] fields,
    output logic                    busy,
    input  logic [NUM_FIELDS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_blank,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W  = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam int PTR_W  = $clog2(NUM_DIGITS);
    localparam int CNT_W  = $clog2(REFRESH_DIV);
    localparam int SLOT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [3:0] CODE_DASH  = 4'hE;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } state_t;

    state_t state;
    state_t state_next;

    logic [NUM_FIELDS-1:0][6:0] snap;
    logic [IDX_W-1:0]           idx;
    logic [6:0]                 rem;
    logic [3:0]                 tens;
    logic [NUM_DIGITS-1:0][3:0] shadow;
    logic [NUM_DIGITS-1:0][3:0] disp;

    logic       capture;
    logic       subtract;
    logic       store;
    logic       commit;
    logic       last_field;
    logic [6:0] cur_val;
    logic [3:0] store_hi;
    logic [3:0] store_lo;

    assign busy       = (state != IDLE);
    assign cur_val    = snap[idx];
    assign last_field = (idx == IDX_W'(NUM_FIELDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Out-of-range values are checked first so they never enter the subtract loop.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        subtract   = 1'b0;
        store      = 1'b0;
        commit     = 1'b0;
        store_hi   = tens;
        store_lo   = rem[3:0];
        case (state)
            IDLE: begin
                if (load) begin
                    capture    = 1'b1;
                    state_next = CONV;
                end
            end
            CONV: begin
                if (cur_val > 7'd99) begin
                    store    = 1'b1;
                    store_hi = CODE_DASH;
                    store_lo = CODE_DASH;
                end else if (rem >= 7'd10) begin
                    subtract = 1'b1;
                end else begin
                    store = 1'b1;
                end
                if (store && last_field) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap   <= '0;
            idx    <= '0;
            rem    <= '0;
            tens   <= '0;
            shadow <= {NUM_DIGITS{CODE_BLANK}};
            disp   <= {NUM_DIGITS{CODE_BLANK}};
        end else begin
            if (capture) begin
                snap <= fields;
                idx  <= '0;
                rem  <= fields[6:0];
                tens <= '0;
            end
            if (subtract) begin
                rem  <= rem - 7'd10;
                tens <= tens + 4'd1;
            end
            if (store) begin
                shadow[{idx, 1'b1}] <= store_hi;
                shadow[{idx, 1'b0}] <= store_lo;
                if (!last_field) begin
                    idx  <= idx + IDX_W'(1);
                    rem  <= snap[idx + IDX_W'(1)];
                    tens <= '0;
                end
            end
            if (commit) begin
                disp <= shadow;
            end
        end
    end

    logic [CNT_W-1:0]      presc;
    logic                  tick;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_next;
    logic [SLOT_W-1:0]     slot;
    logic                  slot_wrap;
    logic                  blink_phase;
    logic                  phase_next;
    logic [IDX_W-1:0]      field_sel;
    logic [3:0]            code;
    logic [6:0]            digit_seg;
    logic                  blinked;
    logic [6:0]            seg_next;
    logic                  dp_next;
    logic [NUM_DIGITS-1:0] an_next;

    assign tick       = (presc == CNT_W'(REFRESH_DIV - 1));
    assign ptr_next   = (ptr == PTR_W'(NUM_DIGITS - 1)) ? '0 : ptr + PTR_W'(1);
    assign slot_wrap  = (slot == SLOT_W'(BLINK_DIV - 1));
    assign phase_next = slot_wrap ? ~blink_phase : blink_phase;
    assign field_sel  = IDX_W'(ptr_next >> 1);

    // Everything is computed for the digit about to be selected, using the blink
    // phase that will hold while that digit is lit.
    always_comb begin
        code      = disp[ptr_next];
        digit_seg = 7'h7F;
        case (code)
            4'd0:      digit_seg = 7'b0000001;
            4'd1:      digit_seg = 7'b1001111;
            4'd2:      digit_seg = 7'b0010010;
            4'd3:      digit_seg = 7'b0000110;
            4'd4:      digit_seg = 7'b1001100;
            4'd5:      digit_seg = 7'b0100100;
            4'd6:      digit_seg = 7'b0100000;
            4'd7:      digit_seg = 7'b0001111;
            4'd8:      digit_seg = 7'b0000000;
            4'd9:      digit_seg = 7'b0000100;
            CODE_DASH: digit_seg = 7'b1111110;
            default:   digit_seg = 7'h7F;
        endcase
        if (lz_blank && ptr_next[0] && (code == 4'd0)) begin
            digit_seg = 7'h7F;
        end
        blinked  = phase_next && blink_mask[field_sel];
        seg_next = blinked ? 7'h7F : digit_seg;
        dp_next  = blinked ? 1'b1 : ~dp_mask[ptr_next];
        an_next  = ~(NUM_DIGITS'(1) << ptr_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc       <= '0;
            ptr         <= PTR_W'(NUM_DIGITS - 1);
            slot        <= '0;
            blink_phase <= 1'b0;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            an          <= '1;
        end else begin
            if (tick) begin
                presc       <= '0;
                ptr         <= ptr_next;
                slot        <= slot_wrap ? '0 : slot + SLOT_W'(1);
                blink_phase <= phase_next;
                seg         <= seg_next;
                dp          <= dp_next;
                an          <= an_next;
            end else begin
                presc <= presc + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_seg_mux_display_gen.sv
// Directed bench for seg_mux_display_gen with a fast refresh (4 clk/slot) and
// a 2-slot blink half-period; expected segment patterns are hand-written per test.
module tb_seg_mux_display_gen;

    localparam int NF = 2;
    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [13:0] fields;
    logic        busy;
    logic [1:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic        lz_blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [6:0] exp_segd [ND];

    always #5 clk = ~clk;

    seg_mux_display_gen #(
        .NUM_FIELDS (NF),
        .REFRESH_DIV(RD),
        .BLINK_DIV  (BD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .fields    (fields),
        .busy      (busy),
        .blink_mask(blink_mask),
        .dp_mask   (dp_mask),
        .lz_blank  (lz_blank),
        .seg       (seg),
        .dp        (dp),
        .an        (an)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    // cyc counts posedges since reset release, so cyc/RD is the number of ticks so far.
    task automatic check_display(input string tag);
        int t;
        int p;
        int ph;
        logic blinked;
        logic [3:0] ea;
        logic [6:0] es;
        logic ed;
        t = cyc / RD;
        if (t == 0) begin
            ea = 4'hF;
            es = 7'h7F;
            ed = 1'b1;
        end else begin
            p       = (t - 1) % ND;
            ph      = (t / BD) % 2;
            blinked = (ph == 1) && blink_mask[p / 2];
            ea      = ~(4'b0001 << p);
            es      = blinked ? 7'h7F : exp_segd[p];
            ed      = blinked ? 1'b1 : ~dp_mask[p];
        end
        checkOutput({tag, "_an"}, an, ea);
        checkOutput({tag, "_seg"}, seg, es);
        checkOutput({tag, "_dp"}, dp, ed);
    endtask

    task automatic scan_check(input string tag, input int n);
        repeat (n) begin
            step();
            while (cyc % RD != 0) step();
            check_display(tag);
        end
    endtask

    task automatic applyStimulus(input logic [13:0] f, input logic [13:0] f_ign,
                                 input int exp_busy, input string tag);
        int n;
        fields = f;
        load   = 1'b1;
        step();
        load = 1'b0;
        n    = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == 2) begin
                fields = f_ign;
                load   = 1'b1;
            end else begin
                load = 1'b0;
            end
            step();
        end
        load = 1'b0;
        checkOutput({tag, "_busy_cycles"}, n, exp_busy);
        step();
        checkOutput({tag, "_not_queued"}, busy, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        load       = 1'b0;
        fields     = '0;
        blink_mask = '0;
        dp_mask    = '0;
        lz_blank   = 1'b0;
        for (int i = 0; i < ND; i++) exp_segd[i] = 7'h7F;

        repeat (2) @(negedge clk);
        checkOutput("rst_busy", busy, 1'b0);
        check_display("rst");
        rst_n = 1'b1;
        cyc   = 0;

        repeat (3) step();
        check_display("pre_tick");
        scan_check("blank_scan", 4);

        for (int i = 0; i < ND; i++) exp_segd[i] = 7'h7F;
        applyStimulus({7'd12, 7'd34}, {7'd99, 7'd99}, 7, "load_1234");
        exp_segd[3] = 7'b1001111;
        exp_segd[2] = 7'b0010010;
        exp_segd[1] = 7'b0000110;
        exp_segd[0] = 7'b1001100;
        scan_check("show_1234", 4);

        lz_blank = 1'b1;
        applyStimulus({7'd5, 7'd120}, {7'd99, 7'd99}, 3, "load_5_120");
        exp_segd[3] = 7'b1111111;
        exp_segd[2] = 7'b0100100;
        exp_segd[1] = 7'b1111110;
        exp_segd[0] = 7'b1111110;
        scan_check("show_5_120", 4);

        blink_mask = 2'b01;
        dp_mask    = 4'b0100;
        scan_check("blink_f0", 8);
        blink_mask = 2'b10;
        scan_check("blink_f1", 4);

        blink_mask = 2'b00;
        dp_mask    = 4'b0000;
        fields     = {7'd59, 7'd59};
        load       = 1'b1;
        step();
        load = 1'b0;
        step();
        step();
        checkOutput("mid_conv_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_an", an, 4'hF);
        checkOutput("arst_seg", seg, 7'h7F);
        checkOutput("arst_dp", dp, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
        for (int i = 0; i < ND; i++) exp_segd[i] = 7'h7F;
        repeat (3) step();
        check_display("post_rst_pre_tick");
        scan_check("post_rst_blank", 4);
        checkOutput("post_rst_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
